// File: rtl/piso_stream_if.sv
// Load/stream bundle for piso_stream: one parallel frame in, valid/ready word stream out.
// The serialiser takes the slave view; whatever feeds and drains it takes the master view.
interface piso_stream_if #(
    parameter int DATA_WID   = 8,
    parameter int MEMORY_WID = 5
);
    localparam int LEN_WID = $clog2(MEMORY_WID + 1);

    logic                           load_valid;
    logic                           load_ready;
    logic [DATA_WID*MEMORY_WID-1:0] load_data;
    logic [LEN_WID-1:0]             load_len;
    logic                           flush;
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WID-1:0]            out_data;
    logic                           out_last;
    logic                           busy;

    modport master (
        output load_valid,
        output load_data,
        output load_len,
        output flush,
        output out_ready,
        input  load_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_len,
        input  flush,
        input  out_ready,
        output load_ready,
        output out_valid,
        output out_data,
        output out_last,
        output busy
    );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in/serial-out frame serialiser: captures up to MEMORY_WID words in one load beat
// and emits them one per accepted beat, marking the final word, with zero-bubble reload.
//
// state | meaning
// IDLE  | no frame held; load_ready follows !flush
// SHIFT | frame in progress; out_data/out_last show the word at idx
module piso_stream #(
    parameter int DATA_WID   = 8,
    parameter int MEMORY_WID = 5,
    parameter int LSW_FIRST  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    piso_stream_if.slave   bus
);
    localparam int LEN_WID = $clog2(MEMORY_WID + 1);
    localparam int IDX_WID = (MEMORY_WID > 1) ? $clog2(MEMORY_WID) : 1;
    localparam logic [LEN_WID-1:0] MAX_LEN = LEN_WID'(MEMORY_WID);
    localparam logic [LEN_WID-1:0] ONE_LEN = LEN_WID'(1);

    typedef enum logic {IDLE, SHIFT} stateT;

    stateT                               state;
    logic [MEMORY_WID-1:0][DATA_WID-1:0] wordBuf;
    logic [MEMORY_WID-1:0][DATA_WID-1:0] loadWords;
    logic [IDX_WID-1:0]                  idx;
    logic [IDX_WID-1:0]                  firstIdx;
    logic [IDX_WID-1:0]                  nextIdx;
    logic [LEN_WID-1:0]                  remaining;
    logic [LEN_WID-1:0]                  remNext;
    logic [LEN_WID-1:0]                  effLen;
    logic [LEN_WID-1:0]                  lenMinus1;
    logic [DATA_WID-1:0]                 outData;
    logic                                outLast;
    logic                                loadReady;
    logic                                loadFire;
    logic                                outFire;

    assign loadWords = bus.load_data;

    // A length of zero or anything past the buffer depth means a full buffer.
    always_comb begin
        effLen = bus.load_len;
        if (bus.load_len == '0 || bus.load_len > MAX_LEN) begin
            effLen = MAX_LEN;
        end
        lenMinus1 = effLen - ONE_LEN;
        firstIdx  = (LSW_FIRST != 0) ? '0 : lenMinus1[IDX_WID-1:0];
        nextIdx   = (LSW_FIRST != 0) ? idx + 1'b1 : idx - 1'b1;
        remNext   = remaining - ONE_LEN;
    end

    // Reload is only possible while the last word is leaving, so the new frame follows directly.
    assign loadReady = rst_n && !bus.flush &&
                       ((state == IDLE) || (state == SHIFT && outLast && bus.out_ready));
    assign loadFire  = bus.load_valid && loadReady;
    assign outFire   = (state == SHIFT) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            state     <= IDLE;
            idx       <= '0;
            remaining <= '0;
            outData   <= '0;
            outLast   <= 1'b0;
        end else if (loadFire) begin
            state     <= SHIFT;
            idx       <= firstIdx;
            remaining <= effLen;
            outData   <= loadWords[firstIdx];
            outLast   <= (effLen == ONE_LEN);
        end else if (outFire) begin
            if (outLast) begin
                state     <= IDLE;
                remaining <= '0;
                outData   <= '0;
                outLast   <= 1'b0;
            end else begin
                idx       <= nextIdx;
                remaining <= remNext;
                outData   <= wordBuf[nextIdx];
                outLast   <= (remNext == ONE_LEN);
            end
        end
    end

    // Buffer contents are don't-care outside a frame, so no reset term.
    always_ff @(posedge clk) begin
        if (loadFire) begin
            wordBuf <= loadWords;
        end
    end

    assign bus.load_ready = loadReady;
    assign bus.out_valid  = (state == SHIFT);
    assign bus.busy       = (state == SHIFT);
    assign bus.out_data   = outData;
    assign bus.out_last   = outLast;
endmodule
